// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - command sequencer driving a 2R/1W register file (option: REGFILE_CTRL_ZERO_REG_EN)
module regfile_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic [1:0]            CmdOp,
    input  logic [ADDR_WIDTH-1:0] CmdAddrA,
    input  logic [ADDR_WIDTH-1:0] CmdAddrB,
    input  logic [DATA_WIDTH-1:0] CmdWriteData,
    output logic                  RspValid,
    input  logic                  RspReady,
    output logic [DATA_WIDTH-1:0] RspData1,
    output logic [DATA_WIDTH-1:0] RspData2,
    output logic                  RfReadWriteEn,
    output logic [ADDR_WIDTH-1:0] RfReadAddress1,
    output logic [ADDR_WIDTH-1:0] RfReadAddress2,
    output logic [ADDR_WIDTH-1:0] RfWriteAddress,
    output logic [DATA_WIDTH-1:0] RfWriteData,
    input  logic [DATA_WIDTH-1:0] RfReadData1,
    input  logic [DATA_WIDTH-1:0] RfReadData2
);

    typedef enum logic [2:0] {IDLE, WR1, RD_ISSUE, RD_CAPT, WR2, RESP} state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

`ifdef REGFILE_CTRL_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] saved_q, saved_d;
    logic                  en_q, en_d;
    logic [ADDR_WIDTH-1:0] ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp1_q, rsp1_d, rsp2_q, rsp2_d;
    logic [DATA_WIDTH-1:0] rd1, rd2;

    // Write-enable level for a write to addr: register 0 is read-only when hardwired.
    function automatic logic wr_en_level(input logic [ADDR_WIDTH-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    // Read addresses stay latched through the whole command, so they double as A/B.
    assign rd1 = (ZERO_REG && ra1_q == '0) ? '0 : RfReadData1;
    assign rd2 = (ZERO_REG && ra2_q == '0) ? '0 : RfReadData2;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        saved_d     = saved_q;
        en_d        = en_q;
        ra1_d       = ra1_q;
        ra2_d       = ra2_q;
        wa_d        = wa_q;
        wd_d        = wd_q;
        rsp_valid_d = rsp_valid_q;
        rsp1_d      = rsp1_q;
        rsp2_d      = rsp2_q;
        case (state_q)
            IDLE: begin
                if (CmdValid) begin
                    op_d = CmdOp;
                    if (CmdOp == OP_WRITE) begin
                        en_d    = wr_en_level(CmdAddrA);
                        wa_d    = CmdAddrA;
                        wd_d    = CmdWriteData;
                        state_d = WR1;
                    end else begin
                        en_d    = 1'b1;
                        ra1_d   = CmdAddrA;
                        ra2_d   = CmdAddrB;
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: state_d = RD_CAPT;
            RD_CAPT: begin
                if (op_q == OP_MOVE) begin
                    en_d    = wr_en_level(ra2_q);
                    wa_d    = ra2_q;
                    wd_d    = rd1;
                    state_d = WR1;
                end else if (op_q == OP_SWAP) begin
                    en_d    = wr_en_level(ra1_q);
                    wa_d    = ra1_q;
                    wd_d    = rd2;
                    saved_d = rd1;
                    state_d = WR1;
                end else begin
                    rsp1_d      = rd1;
                    rsp2_d      = rd2;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            WR1: begin
                if (op_q == OP_SWAP) begin
                    en_d    = wr_en_level(ra2_q);
                    wa_d    = ra2_q;
                    wd_d    = saved_q;
                    state_d = WR2;
                end else begin
                    en_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            WR2: begin
                en_d    = 1'b1;
                state_d = IDLE;
            end
            RESP: begin
                if (RspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                en_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            saved_q     <= '0;
            en_q        <= 1'b1;
            ra1_q       <= '0;
            ra2_q       <= '0;
            wa_q        <= '0;
            wd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp1_q      <= '0;
            rsp2_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            saved_q     <= saved_d;
            en_q        <= en_d;
            ra1_q       <= ra1_d;
            ra2_q       <= ra2_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp1_q      <= rsp1_d;
            rsp2_q      <= rsp2_d;
        end
    end

    assign CmdReady       = (state_q == IDLE);
    assign RspValid       = rsp_valid_q;
    assign RspData1       = rsp1_q;
    assign RspData2       = rsp2_q;
    assign RfReadWriteEn  = en_q;
    assign RfReadAddress1 = ra1_q;
    assign RfReadAddress2 = ra2_q;
    assign RfWriteAddress = wa_q;
    assign RfWriteData    = wd_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - directed bench with register-file model and command-level reference model
module tb_regfile_access_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;

`ifdef REGFILE_CTRL_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          CmdValid, CmdReady, RspValid, RspReady, RfReadWriteEn;
    logic [1:0]    CmdOp;
    logic [AW-1:0] CmdAddrA, CmdAddrB, RfReadAddress1, RfReadAddress2, RfWriteAddress;
    logic [DW-1:0] CmdWriteData, RspData1, RspData2, RfWriteData, RfReadData1, RfReadData2;

    regfile_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp),
        .CmdAddrA(CmdAddrA), .CmdAddrB(CmdAddrB), .CmdWriteData(CmdWriteData),
        .RspValid(RspValid), .RspReady(RspReady), .RspData1(RspData1), .RspData2(RspData2),
        .RfReadWriteEn(RfReadWriteEn), .RfReadAddress1(RfReadAddress1),
        .RfReadAddress2(RfReadAddress2), .RfWriteAddress(RfWriteAddress),
        .RfWriteData(RfWriteData), .RfReadData1(RfReadData1), .RfReadData2(RfReadData2)
    );

    // Register file: writes when enable is 0, registered reads when 1.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (!RfReadWriteEn) mem[RfWriteAddress] <= RfWriteData;
        else begin
            RfReadData1 <= mem[RfReadAddress1];
            RfReadData2 <= mem[RfReadAddress2];
        end
    end

    int total = 0;
    int bad = 0;
    int wr_cycles = 0;
    logic [DW-1:0] golden [32];
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t exp_wr[$];
    logic [2*DW-1:0] exp_rsp[$];
    logic [DW-1:0] last1, last2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit is_zr(input logic [AW-1:0] a);
        return ZR && (a == '0);
    endfunction

    function automatic logic [DW-1:0] val(input logic [AW-1:0] a);
        return is_zr(a) ? '0 : golden[a];
    endfunction

    // Command semantics applied atomically at acceptance.
    task automatic model_accept(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                                input logic [DW-1:0] d);
        logic [DW-1:0] va, vb;
        va = val(a);
        vb = val(b);
        case (op)
            2'b00: if (!is_zr(a)) begin golden[a] = d; exp_wr.push_back('{a, d}); end
            2'b01: exp_rsp.push_back({va, vb});
            2'b10: if (!is_zr(b)) begin golden[b] = va; exp_wr.push_back('{b, va}); end
            default: begin
                if (!is_zr(a)) begin golden[a] = vb; exp_wr.push_back('{a, vb}); end
                if (!is_zr(b)) begin golden[b] = va; exp_wr.push_back('{b, va}); end
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (!RfReadWriteEn) begin
                wr_cycles++;
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write actual=addr %0d data %h required=no write", RfWriteAddress, RfWriteData);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", 64'(RfWriteAddress), 64'(w.a));
                    chk("wr_data", 64'(RfWriteData), 64'(w.d));
                end
            end
            if (RspValid && RspReady) begin
                last1 = RspData1;
                last2 = RspData2;
                if (exp_rsp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp actual=%h %h required=no response", RspData1, RspData2);
                end else begin
                    logic [2*DW-1:0] r;
                    r = exp_rsp.pop_front();
                    chk("rsp_data1", 64'(RspData1), 64'(r[2*DW-1:DW]));
                    chk("rsp_data2", 64'(RspData2), 64'(r[DW-1:0]));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] d, input bit model);
        int n;
        n = 0;
        @(negedge clk);
        CmdValid = 1'b1; CmdOp = op; CmdAddrA = a; CmdAddrB = b; CmdWriteData = d;
        while (!CmdReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!CmdReady) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=CmdReady 0 required=1");
            CmdValid = 1'b0;
        end else begin
            @(posedge clk);
            if (model) model_accept(op, a, b, d);
            #1 CmdValid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(CmdReady && !RspValid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 64'(CmdReady && !RspValid), 64'd1);
    endtask

    initial begin
        int w0, n;
        logic [DW-1:0] d1, d2;
        for (int i = 0; i < 32; i++) begin mem[i] = '0; golden[i] = '0; end
        CmdValid = 0; CmdOp = 0; CmdAddrA = 0; CmdAddrB = 0; CmdWriteData = 0; RspReady = 1;
        last1 = '0; last2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_en", 64'(RfReadWriteEn), 64'd1);
        chk("rst_waddr", 64'(RfWriteAddress), 64'd0);
        chk("rst_wdata", 64'(RfWriteData), 64'd0);
        chk("rst_raddr1", 64'(RfReadAddress1), 64'd0);
        chk("rst_rspvalid", 64'(RspValid), 64'd0);
        chk("rst_rspdata1", 64'(RspData1), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(CmdReady), 64'd1);

        // WRITE: one write cycle, ready low exactly one cycle
        w0 = wr_cycles;
        issue(2'b00, 5'd5, 5'd0, 32'h12345678, 1'b1);
        @(negedge clk);
        chk("wr_ready_low", 64'(CmdReady), 64'd0);
        chk("wr_en_low", 64'(RfReadWriteEn), 64'd0);
        chk("wr_addr5", 64'(RfWriteAddress), 64'd5);
        @(negedge clk);
        chk("wr_ready_back", 64'(CmdReady), 64'd1);
        chk("wr_en_back", 64'(RfReadWriteEn), 64'd1);
        wait_idle();
        chk("write_once", 64'(wr_cycles - w0), 64'd1);

        // READ2 latency and data
        issue(2'b00, 5'd15, 5'd0, 32'habcdabcd, 1'b1);
        issue(2'b01, 5'd5, 5'd15, 32'h0, 1'b1);
        @(negedge clk); chk("rd_lat0", 64'(RspValid), 64'd0);
        @(negedge clk); chk("rd_lat1", 64'(RspValid), 64'd0);
        @(negedge clk); chk("rd_lat2", 64'(RspValid), 64'd1);
        wait_idle();
        chk("rd_lit1", 64'(last1), 64'h12345678);
        chk("rd_lit2", 64'(last2), 64'habcdabcd);

        // Response backpressure
        RspReady = 1'b0;
        issue(2'b01, 5'd15, 5'd5, 32'h0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!RspValid && n < 20) begin @(negedge clk); n++; end
        chk("bp_valid_seen", 64'(RspValid), 64'd1);
        d1 = RspData1; d2 = RspData2;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_hold", 64'(RspValid), 64'd1);
            chk("bp_data_hold", {32'(RspData1), 32'(RspData2)}, {32'(d1), 32'(d2)});
            chk("bp_ready_low", 64'(CmdReady), 64'd0);
        end
        @(posedge clk);
        #1 RspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_released", 64'(RspValid), 64'd0);
        chk("bp_ready_back", 64'(CmdReady), 64'd1);
        chk("bp_lit", {32'(last1), 32'(last2)}, 64'habcdabcd_12345678);

        // MOVE 5 -> 7
        w0 = wr_cycles;
        issue(2'b10, 5'd5, 5'd7, 32'h0, 1'b1);
        wait_idle();
        chk("move_one_write", 64'(wr_cycles - w0), 64'd1);
        issue(2'b01, 5'd7, 5'd5, 32'h0, 1'b1);
        wait_idle();
        chk("move_lit", {32'(last1), 32'(last2)}, 64'h12345678_12345678);

        // SWAP 5,15 and SWAP 9,9
        w0 = wr_cycles;
        issue(2'b11, 5'd5, 5'd15, 32'h0, 1'b1);
        wait_idle();
        chk("swap_two_writes", 64'(wr_cycles - w0), 64'd2);
        issue(2'b01, 5'd5, 5'd15, 32'h0, 1'b1);
        wait_idle();
        chk("swap_lit", {32'(last1), 32'(last2)}, 64'habcdabcd_12345678);
        issue(2'b00, 5'd9, 5'd0, 32'h99990000, 1'b1);
        issue(2'b11, 5'd9, 5'd9, 32'h0, 1'b1);
        issue(2'b01, 5'd9, 5'd9, 32'h0, 1'b1);
        wait_idle();
        chk("swap_same_lit", {32'(last1), 32'(last2)}, 64'h99990000_99990000);

        // Reset during WR1 suppresses the write
        issue(2'b00, 5'd3, 5'd0, 32'h11111111, 1'b1);
        wait_idle();
        issue(2'b00, 5'd3, 5'd0, 32'hdeadbeef, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_en", 64'(RfReadWriteEn), 64'd1);
        @(negedge clk);
        chk("rst_mid_rspvalid", 64'(RspValid), 64'd0);
        rst_n = 1'b1;
        issue(2'b01, 5'd3, 5'd3, 32'h0, 1'b1);
        wait_idle();
        chk("rst_old_value", {32'(last1), 32'(last2)}, 64'h11111111_11111111);

        // Register 0 behaviour
        w0 = wr_cycles;
        issue(2'b00, 5'd0, 5'd0, 32'hffffffff, 1'b1);
        issue(2'b01, 5'd0, 5'd0, 32'h0, 1'b1);
        wait_idle();
`ifdef REGFILE_CTRL_ZERO_REG_EN
        chk("zr_no_write", 64'(wr_cycles - w0), 64'd0);
        chk("zr_read", {32'(last1), 32'(last2)}, 64'h0);
`else
        chk("r0_write", 64'(wr_cycles - w0), 64'd1);
        chk("r0_read", {32'(last1), 32'(last2)}, 64'hffffffff_ffffffff);
`endif

        repeat (3) @(negedge clk);
        chk("writes_drained", 64'(exp_wr.size()), 64'd0);
        chk("rsps_drained", 64'(exp_rsp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
